// File: rtl/cache_block_buffer.sv
// cache_block_buffer: word-serial transfer buffer between a cache controller's
// memory command/buffer ports and a word-wide external memory interface.
// A single- or whole-block command is split into per-word external requests.
// Read fill data waits in a read FIFO until the cache pops it. Writeback data
// is collected into a write FIFO before it is issued.
// Optional build macro CACHE_BLOCK_BUFFER_ERR_EN adds the sticky err_o and
// err_code_o outputs. These flag the ignored-input conditions.
module cache_block_buffer #(
    parameter int BW_ADDR  = 24,
    parameter int BW_BLOCK = 2
) (
    input  logic                clock_i,
    input  logic                resetn_i,
    input  logic                req_i,
    input  logic                req_block_i,
    input  logic                rw_i,
    input  logic [BW_ADDR-1:0]  add_i,
    output logic                ready_req_o,
    input  logic                write_i,
    input  logic [31:0]         data_i,
    output logic                ready_write_o,
    input  logic                read_i,
    output logic                ready_read_o,
    output logic [31:0]         data_o,
    output logic                ext_req_o,
    output logic                ext_rw_o,
    output logic [BW_ADDR-1:0]  ext_add_o,
    output logic [31:0]         ext_data_o,
    input  logic                ext_ready_i,
    input  logic                ext_valid_i,
    input  logic [31:0]         ext_data_i
`ifdef CACHE_BLOCK_BUFFER_ERR_EN
    ,
    output logic                err_o,
    output logic [2:0]          err_code_o
`endif
);

    localparam int N_BLK  = 1 << BW_BLOCK;
    localparam int BW_CNT = BW_BLOCK + 1;
    localparam logic [BW_ADDR-1:0] BLK_MASK = BW_ADDR'(N_BLK - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_DRAIN,
        S_WR_COLLECT,
        S_WR_ISSUE
    } state_t;

    state_t                r_state;
    logic [BW_ADDR-1:0]    r_base;
    logic [BW_CNT-1:0]     r_cnt;
    logic [BW_CNT-1:0]     r_iss;
    logic [BW_CNT-1:0]     r_rcv;
    logic [BW_CNT-1:0]     r_col;

    // Read FIFO (fill data heading to the cache)
    logic [31:0]           r_rd_mem [N_BLK];
    logic [BW_BLOCK-1:0]   r_rd_wptr;
    logic [BW_BLOCK-1:0]   r_rd_rptr;
    logic [BW_CNT-1:0]     r_rd_count;

    // Write FIFO (writeback data heading to external memory)
    logic [31:0]           r_wr_mem [N_BLK];
    logic [BW_BLOCK-1:0]   r_wr_wptr;
    logic [BW_BLOCK-1:0]   r_wr_rptr;
    logic [BW_CNT-1:0]     r_wr_count;

    logic                  w_in_rd;
    logic                  w_accept;
    logic [BW_ADDR-1:0]    w_base;
    logic                  w_rd_push;
    logic                  w_rd_pop;
    logic [BW_CNT-1:0]     w_rd_count_next;
    logic [BW_CNT-1:0]     w_rcv_next;
    logic                  w_iss_inc;
    logic [BW_CNT-1:0]     w_iss_next;
    logic                  w_wr_push;
    logic                  w_wr_pop;
    logic [BW_CNT-1:0]     w_col_next;

    // Outputs are decoded purely from registered state, so they never depend
    // combinationally on the handshake inputs.
    assign ready_req_o   = (r_state == S_IDLE);
    assign ext_req_o     = (r_state == S_RD_ISSUE) || (r_state == S_WR_ISSUE);
    assign ext_rw_o      = (r_state == S_WR_ISSUE);
    assign ext_add_o     = ext_req_o ? (r_base + BW_ADDR'(r_iss)) : '0;
    assign ext_data_o    = (r_state == S_WR_ISSUE) ? r_wr_mem[r_wr_rptr] : '0;
    assign ready_write_o = (r_state == S_WR_COLLECT) && (r_col < r_cnt);
    assign ready_read_o  = (r_rd_count != '0);
    assign data_o        = ready_read_o ? r_rd_mem[r_rd_rptr] : '0;

    assign w_in_rd   = (r_state == S_RD_ISSUE) || (r_state == S_RD_DRAIN);
    assign w_accept  = req_i && ready_req_o;
    // A block command always starts at the first word of its block.
    assign w_base    = req_block_i ? (add_i & ~BLK_MASK) : add_i;

    // Responses beyond the expected count (or after an abort) are dropped.
    assign w_rd_push = ext_valid_i && w_in_rd && (r_rcv < r_cnt);
    assign w_rd_pop  = read_i && ready_read_o;
    assign w_rd_count_next = r_rd_count + BW_CNT'(w_rd_push) - BW_CNT'(w_rd_pop);
    assign w_rcv_next      = r_rcv + BW_CNT'(w_rd_push);

    assign w_iss_inc  = ext_req_o && ext_ready_i;
    assign w_iss_next = r_iss + BW_CNT'(w_iss_inc);

    assign w_wr_push  = write_i && ready_write_o;
    assign w_wr_pop   = w_iss_inc && (r_state == S_WR_ISSUE);
    assign w_col_next = r_col + BW_CNT'(w_wr_push);

    // Control FSM: command latch, word counters and state sequencing
    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_cnt   <= '0;
            r_iss   <= '0;
            r_rcv   <= '0;
            r_col   <= '0;
        end else begin
            r_iss <= w_iss_next;
            r_rcv <= w_rcv_next;
            r_col <= w_col_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_base  <= w_base;
                        r_cnt   <= req_block_i ? BW_CNT'(N_BLK) : BW_CNT'(1);
                        r_iss   <= '0;
                        r_rcv   <= '0;
                        r_col   <= '0;
                        r_state <= rw_i ? S_WR_COLLECT : S_RD_ISSUE;
                    end
                end
                S_RD_ISSUE: begin
                    if (w_iss_next == r_cnt) r_state <= S_RD_DRAIN;
                end
                S_RD_DRAIN: begin
                    if ((w_rcv_next == r_cnt) && (w_rd_count_next == '0)) r_state <= S_IDLE;
                end
                S_WR_COLLECT: begin
                    if (w_col_next == r_cnt) r_state <= S_WR_ISSUE;
                end
                S_WR_ISSUE: begin
                    if (w_iss_next == r_cnt) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Read FIFO storage and pointers; push and pop may coincide
    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            r_rd_wptr  <= '0;
            r_rd_rptr  <= '0;
            r_rd_count <= '0;
            for (int i = 0; i < N_BLK; i++) r_rd_mem[i] <= '0;
        end else begin
            if (w_rd_push) begin
                r_rd_mem[r_rd_wptr] <= ext_data_i;
                r_rd_wptr           <= r_rd_wptr + BW_BLOCK'(1);
            end
            if (w_rd_pop) r_rd_rptr <= r_rd_rptr + BW_BLOCK'(1);
            r_rd_count <= w_rd_count_next;
        end
    end

    // Write FIFO storage and pointers; filled while collecting, drained while issuing
    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            r_wr_wptr  <= '0;
            r_wr_rptr  <= '0;
            r_wr_count <= '0;
            for (int i = 0; i < N_BLK; i++) r_wr_mem[i] <= '0;
        end else begin
            if (w_wr_push) begin
                r_wr_mem[r_wr_wptr] <= data_i;
                r_wr_wptr           <= r_wr_wptr + BW_BLOCK'(1);
            end
            if (w_wr_pop) r_wr_rptr <= r_wr_rptr + BW_BLOCK'(1);
            r_wr_count <= r_wr_count + BW_CNT'(w_wr_push) - BW_CNT'(w_wr_pop);
        end
    end

`ifdef CACHE_BLOCK_BUFFER_ERR_EN
    logic       r_err;
    logic [2:0] r_err_code;
    logic       w_err_busy;
    logic       w_err_wr;
    logic       w_err_rd;
    logic       w_err_val;

    assign w_err_busy = req_i && !ready_req_o;
    assign w_err_wr   = write_i && !ready_write_o;
    assign w_err_rd   = read_i && !ready_read_o;
    assign w_err_val  = ext_valid_i && !w_rd_push;

    assign err_o      = r_err;
    assign err_code_o = r_err_code;

    // Sticky error flag that keeps only the first cause seen since reset
    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            r_err      <= 1'b0;
            r_err_code <= 3'd0;
        end else if (!r_err && (w_err_busy || w_err_wr || w_err_rd || w_err_val)) begin
            r_err <= 1'b1;
            if (w_err_busy)    r_err_code <= 3'd1;
            else if (w_err_wr) r_err_code <= 3'd2;
            else if (w_err_rd) r_err_code <= 3'd3;
            else               r_err_code <= 3'd4;
        end
    end
`endif

endmodule
